// File: rtl/frame_sum_reporter.sv
// Frame sum reporter: sums every FRAME_LEN qualified samples, queues {seq, sum} results in a
// small FIFO behind a valid/ready port and counts frames lost to backpressure.
// Optional macro FRAME_PEAK_EN adds a per-frame peak sample (res_peak) to each queued result.
module frame_sum_reporter #(
  parameter int DATA_W     = 8,
  parameter int FRAME_LEN  = 8,
  parameter int SUM_W      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SUM_W-1:0]  res_data,
  output logic [3:0]        res_seq,
  output logic [2:0]        fifo_level,
  output logic [7:0]        drop_cnt
`ifdef FRAME_PEAK_EN
  ,
  output logic [DATA_W-1:0] res_peak
`endif
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef FRAME_PEAK_EN
  localparam int ENTRY_W = 4 + SUM_W + DATA_W;
`else
  localparam int ENTRY_W = 4 + SUM_W;
`endif

  logic [CNT_W-1:0]   cnt_reg;
  logic [SUM_W-1:0]   acc_reg;
  logic [3:0]         seq_reg;
  logic [7:0]         drop_reg;
  logic [2:0]         level_reg;
  logic               valid_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [ENTRY_W-1:0] head_reg;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

  logic               take;
  logic               last;
  logic               pop;
  logic               full;
  logic               push;
  logic [SUM_W-1:0]   sample_ext;
  logic [SUM_W-1:0]   sum_next;
  logic [ENTRY_W-1:0] push_entry;
  logic [PTR_W-1:0]   rd_next;
  logic [2:0]         level_next;
  logic [ENTRY_W-1:0] head_next;

  assign take       = sample_valid && !flush;
  assign last       = take && (cnt_reg == CNT_W'(FRAME_LEN - 1));
  assign sample_ext = SUM_W'(sample);
  assign sum_next   = (cnt_reg == '0) ? sample_ext : (acc_reg + sample_ext);

  // A full FIFO still accepts a closing frame when the head leaves in the same cycle.
  assign pop        = valid_reg && res_ready;
  assign full       = (level_reg == 3'(FIFO_DEPTH));
  assign push       = last && (!full || pop);
  assign rd_next    = rd_ptr_reg + PTR_W'(pop);
  assign level_next = level_reg + 3'(push) - 3'(pop);

`ifdef FRAME_PEAK_EN
  logic [DATA_W-1:0] peak_reg;
  logic [DATA_W-1:0] peak_cur;

  assign peak_cur   = (cnt_reg == '0) ? sample :
                      ((sample > peak_reg) ? sample : peak_reg);
  assign push_entry = {seq_reg, sum_next, peak_cur};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_reg <= '0;
    end else if (flush) begin
      peak_reg <= '0;
    end else if (take) begin
      peak_reg <= peak_cur;
    end
  end

  assign res_peak = head_reg[DATA_W-1:0];
`else
  assign push_entry = {seq_reg, sum_next};
`endif

  // Frame accumulator, sample counter and sequence tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      acc_reg <= '0;
      seq_reg <= '0;
    end else if (flush) begin
      cnt_reg <= '0;
      acc_reg <= '0;
    end else if (take) begin
      acc_reg <= sum_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (last) begin
        seq_reg <= seq_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_reg <= '0;
    end else if (last && !push && (drop_reg != 8'hFF)) begin
      drop_reg <= drop_reg + 8'd1;
    end
  end

  // Storage has no reset; it is only read once a push has made the slot valid.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem[gi] <= push_entry;
        end
      end
    end
  endgenerate

  // Next head: the entry being written this cycle if it lands at the new read slot.
  always_comb begin
    head_next = head_reg;
    if (level_next != 3'd0) begin
      if (push && (wr_ptr_reg == rd_next)) begin
        head_next = push_entry;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      valid_reg  <= 1'b0;
      head_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_next;
      level_reg  <= level_next;
      valid_reg  <= (level_next != 3'd0);
      head_reg   <= head_next;
    end
  end

  assign res_valid  = valid_reg;
  assign fifo_level = level_reg;
  assign drop_cnt   = drop_reg;
  assign res_seq    = head_reg[ENTRY_W-1 -: 4];
  assign res_data   = head_reg[ENTRY_W-5 -: SUM_W];

endmodule

// File: tb/tb_frame_sum_reporter.sv
// Self-checking bench for frame_sum_reporter: directed cases plus randomized traffic
// compared every cycle against a queue-based frame/result model.
module tb_frame_sum_reporter;

  localparam int DATA_W     = 8;
  localparam int FRAME_LEN  = 8;
  localparam int SUM_W      = 11;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample = '0;
  logic              flush = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [SUM_W-1:0]  res_data;
  logic [3:0]        res_seq;
  logic [2:0]        fifo_level;
  logic [7:0]        drop_cnt;
`ifdef FRAME_PEAK_EN
  logic [DATA_W-1:0] res_peak;
`endif

  frame_sum_reporter #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .SUM_W(SUM_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_seq(res_seq),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
`ifdef FRAME_PEAK_EN
    , .res_peak(res_peak)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int seq;
    int sum;
    int peak;
  } ent_t;

  ent_t mq[$];
  int   frame_q[$];
  int   m_seq  = 0;
  int   m_drop = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // One clock of model behaviour, from the pre-edge state and the inputs of that cycle.
  task automatic model_step(input bit sv, input int s, input bit fl, input bit rdy);
    ent_t e;
    bit closed = 1'b0;
    int sum = 0;
    int pk  = 0;
    bit pop = (mq.size() > 0) && rdy;
    if (fl) begin
      frame_q.delete();
    end else if (sv) begin
      frame_q.push_back(s);
      if (frame_q.size() == FRAME_LEN) begin
        foreach (frame_q[k]) begin
          sum += frame_q[k];
          if (frame_q[k] > pk) pk = frame_q[k];
        end
        closed = 1'b1;
        frame_q.delete();
      end
    end
    if (pop) void'(mq.pop_front());
    if (closed) begin
      if (mq.size() < FIFO_DEPTH) begin
        e.seq = m_seq; e.sum = sum; e.peak = pk;
        mq.push_back(e);
      end else if (m_drop < 255) begin
        m_drop++;
      end
      m_seq = (m_seq + 1) % 16;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("res_valid", 32'(res_valid), 32'(mq.size() != 0));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (mq.size() != 0) begin
        chk("res_data", 32'(res_data), 32'(mq[0].sum));
        chk("res_seq", 32'(res_seq), 32'(mq[0].seq));
`ifdef FRAME_PEAK_EN
        chk("res_peak", 32'(res_peak), 32'(mq[0].peak));
`endif
        if (res_ready) $display("pop seq=%0d data=%0h level=%0d", res_seq, res_data, fifo_level);
      end
    end
  end

  task automatic cyc(input bit sv, input int s, input bit fl, input bit rdy);
    sample_valid = sv;
    sample       = DATA_W'(s);
    flush        = fl;
    res_ready    = rdy;
    @(posedge clk);
    model_step(sv, s, fl, rdy);
    @(negedge clk);
  endtask

  task automatic frame(input int val, input bit rdy);
    for (int i = 0; i < FRAME_LEN; i++) cyc(1'b1, val, 1'b0, rdy);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2;
    chk_en       = 1'b0;
    sample_valid = 1'b0;
    flush        = 1'b0;
    res_ready    = 1'b0;
    rst          = 1'b1;
    #1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    mq.delete();
    frame_q.delete();
    m_seq  = 0;
    m_drop = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    #2;
    chk("init_valid", 32'(res_valid), 32'd0);
    chk("init_data", 32'(res_data), 32'd0);
    chk("init_seq", 32'(res_seq), 32'd0);
    chk("init_level", 32'(fifo_level), 32'd0);
    chk("init_drop", 32'(drop_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Eight 0x01 samples: result one cycle after the closing sample, then popped.
    frame(8'h01, 1'b1);
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_data", 32'(res_data), 32'd8);
    chk("t1_seq", 32'(res_seq), 32'd0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("t1_pulse", 32'(res_valid), 32'd0);

    // Eight 0xFF samples: full-width sum without wrap.
    frame(8'hFF, 1'b1);
    chk("t2_data", 32'(res_data), 32'h7F8);
    chk("t2_seq", 32'(res_seq), 32'd1);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Five frames under backpressure: four queued, one dropped.
    do_reset();
    for (int f = 0; f < 5; f++) frame(8'h10, 1'b0);
    chk("t3_level", 32'(fifo_level), 32'd4);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_qseq", 32'(res_seq), 32'(i));
      chk("t3_qdata", 32'(res_data), 32'h80);
      cyc(1'b0, 0, 1'b0, 1'b1);
    end
    chk("t3_empty", 32'(fifo_level), 32'd0);
    frame(8'h10, 1'b1);
    chk("t3_nextseq", 32'(res_seq), 32'd5);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Flush a partial frame, including a coincident sample, then a clean frame.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b0, 1'b1);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == FRAME_LEN - 1) chk("t4_nopartial", 32'(res_valid), 32'd0);
      cyc(1'b1, 8'h02, 1'b0, 1'b1);
    end
    chk("t4_valid", 32'(res_valid), 32'd1);
    chk("t4_data", 32'(res_data), 32'h010);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Full FIFO with a pop on the closing-sample cycle: push accepted.
    for (int f = 0; f < 4; f++) frame(8'h04, 1'b0);
    for (int i = 0; i < FRAME_LEN; i++) cyc(1'b1, 8'h05, 1'b0, i == FRAME_LEN - 1);
    chk("t5_level", 32'(fifo_level), 32'd4);
    chk("t5_drop", 32'(drop_cnt), 32'd1);

    // Reset mid-frame with two results queued, then a fresh frame starts at seq 0.
    do_reset();
    frame(8'h01, 1'b0);
    frame(8'h02, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h09, 1'b0, 1'b0);
    chk("t6_pre_level", 32'(fifo_level), 32'd2);
    do_reset();
    frame(8'h03, 1'b1);
    chk("t6_data", 32'(res_data), 32'd24);
    chk("t6_seq", 32'(res_seq), 32'd0);
    for (int i = 1; i <= FRAME_LEN; i++) cyc(1'b1, i, 1'b0, 1'b1);
    chk("t6_sum", 32'(res_data), 32'd36);
`ifdef FRAME_PEAK_EN
    chk("t6_peak", 32'(res_peak), 32'd8);
`endif
    cyc(1'b0, 0, 1'b0, 1'b1);

    // Randomized traffic with alternating light and heavy backpressure.
    for (int i = 0; i < 4000; i++) begin
      bit sv  = ($urandom % 4) != 0;
      int s   = int'($urandom_range(0, 255));
      bit fl  = ($urandom % 40) == 0;
      bit rdy = ((i / 500) % 2 == 1) ? (($urandom % 6) == 0) : (($urandom % 3) != 0);
      cyc(sv, s, fl, rdy);
      if (i % 1500 == 1499) do_reset();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
